// File: rtl/sensor_spi_slave_tx_pkg.sv
// sensor_spi_slave_tx_pkg: shared frame constants, FSM encoding and frame-count helper
package sensor_spi_slave_tx_pkg;
  localparam int FRAME_BITS = 128;
  localparam int HEADER_BITS = 8;
  localparam int TOTAL_BITS = FRAME_BITS + HEADER_BITS;
  localparam logic [3:0] HEADER_TAG = 4'h5;
  localparam logic [7:0] REWIND_CMD = 8'hA5;
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;
  function automatic int frame_count(int sensors);
    return (sensors + 3) / 4;
  endfunction
endpackage

// File: rtl/spi_input_sync.sv
// spi_input_sync: 2-FF synchroniser with rise/fall pulses on the synchronised level
// ports: clock, reset_n (async, active low); d (pad input); q (synchronised level); rise/fall (1-cycle edge pulses)
module spi_input_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic meta, prev;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) {meta, q, prev} <= {3{RESET_VAL}};
    else {meta, q, prev} <= {d, meta, q};
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/sensor_spi_slave_tx.sv
// sensor_spi_slave_tx: SPI mode-0 slave streaming one header plus four sensor words per CS_n transaction
// ports: clock, reset_n (async, active low); sensor_data_i (packed sensor words, sensor k at [32k+31:32k]);
//        sclk_i, cs_n_i, mosi_i (host SPI, asynchronous); miso_o, miso_oe_o (MISO data and pad enable);
//        frame_done_o (pulse after 136 bits); overrun_o (sticky, extra SCLK falls past the frame)
module sensor_spi_slave_tx
  import sensor_spi_slave_tx_pkg::*;
#(
  parameter int NUMBER_OF_SENSORS = 20
) (
  input  logic clock,
  input  logic reset_n,
  input  logic [frame_count(NUMBER_OF_SENSORS)*FRAME_BITS-1:0] sensor_data_i,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic miso_o,
  output logic miso_oe_o,
  output logic frame_done_o,
  output logic overrun_o
);
  localparam int NUMBER_OF_SPI_FRAMES = frame_count(NUMBER_OF_SENSORS);
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic sclk_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;
  state_t state_q, state_d;
  logic [TOTAL_BITS-1:0] shift_q, shift_d;
  logic [7:0] bit_cnt_q, bit_cnt_d, cmd_q, cmd_d;
  logic [3:0] cmd_cnt_q, cmd_cnt_d, idx_q, idx_d, next_idx;
  logic done_q, done_d, overrun_q, overrun_d;
  spi_input_sync #(.RESET_VAL(1'b0)) u_sclk (.clock(clock), .reset_n(reset_n), .d(sclk_i), .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
  spi_input_sync #(.RESET_VAL(1'b1)) u_cs (.clock(clock), .reset_n(reset_n), .d(cs_n_i), .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall));
  spi_input_sync #(.RESET_VAL(1'b0)) u_mosi (.clock(clock), .reset_n(reset_n), .d(mosi_i), .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));
  assign next_idx = (idx_q == 4'(NUMBER_OF_SPI_FRAMES - 1)) ? 4'd0 : idx_q + 4'd1;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_cnt_q <= '0;
      cmd_q <= '0;
      cmd_cnt_q <= '0;
      idx_q <= '0;
      done_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q <= cmd_d;
      cmd_cnt_q <= cmd_cnt_d;
      idx_q <= idx_d;
      done_q <= done_d;
      overrun_q <= overrun_d;
    end
  // CS rise is checked first so it wins over any SCLK edge in the same cycle
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d = cmd_q;
    cmd_cnt_d = cmd_cnt_q;
    idx_d = idx_q;
    done_d = 1'b0;
    overrun_d = overrun_q;
    if (cs_rise && state_q != IDLE) begin
      state_d = IDLE;
      idx_d = (cmd_cnt_q == 4'd8 && cmd_q == REWIND_CMD) ? 4'd0 :
              (bit_cnt_q == 8'(TOTAL_BITS)) ? next_idx : idx_q;
    end else begin
      case (state_q)
        IDLE: if (cs_fall) begin
          shift_d = {HEADER_TAG, idx_q, sensor_data_i[32'(idx_q)*FRAME_BITS +: FRAME_BITS]};
          bit_cnt_d = '0;
          cmd_d = '0;
          cmd_cnt_d = '0;
          overrun_d = 1'b0;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (sclk_rise && cmd_cnt_q != 4'd8) begin
            cmd_d = {cmd_q[6:0], mosi_s};
            cmd_cnt_d = cmd_cnt_q + 4'd1;
          end
          if (sclk_fall) begin
            shift_d = {shift_q[TOTAL_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 8'd1;
            if (bit_cnt_q == 8'(TOTAL_BITS - 1)) begin
              state_d = DRAIN;
              done_d = 1'b1;
            end
          end
        end
        DRAIN: if (sclk_fall) overrun_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end
  assign miso_o = (state_q == SHIFT) & shift_q[TOTAL_BITS-1];
  assign miso_oe_o = state_q != IDLE;
  assign frame_done_o = done_q;
  assign overrun_o = overrun_q;
endmodule
